// File: rtl/game_pkg.sv
// ============================================================================
//  Module      : game_pkg
//  Description : Shared definitions for the frame sequencer: default slot
//                count and watchdog limit, counter widths, the sequencer
//                state encoding and a saturating increment helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int C_NTASK_DEF   = 4;
    localparam int C_TIMEOUT_DEF = 4096;
    localparam int C_FRAME_CNT_W = 16;
    localparam int C_DROP_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_t;

    // Saturating increment for the dropped-frame counter.
    function automatic logic [C_DROP_CNT_W-1:0] sat_inc_drop(
        input logic [C_DROP_CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_sequencer_if.sv
// ============================================================================
//  Module      : frame_sequencer_if
//  Description : Bundle of the frame sequencer's control and status signals.
//                master = frame timing / game logic side, slave = sequencer.
//  Signals     : vsync, enable, err_clr, task_done  (master -> slave)
//                task_start, busy, frame_count, overrun, dropped,
//                task_timeout                       (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_sequencer_if #(
    parameter int NTASK = game_pkg::C_NTASK_DEF
);
    import game_pkg::*;

    logic                     vsync;
    logic                     enable;
    logic                     err_clr;
    logic [NTASK-1:0]         task_done;
    logic [NTASK-1:0]         task_start;
    logic                     busy;
    logic [C_FRAME_CNT_W-1:0] frame_count;
    logic                     overrun;
    logic [C_DROP_CNT_W-1:0]  dropped;
    logic [NTASK-1:0]         task_timeout;

    modport master (
        output vsync, enable, err_clr, task_done,
        input  task_start, busy, frame_count, overrun, dropped, task_timeout
    );

    modport slave (
        input  vsync, enable, err_clr, task_done,
        output task_start, busy, frame_count, overrun, dropped, task_timeout
    );

endinterface

`default_nettype wire

// File: rtl/seq_watchdog.sv
// ============================================================================
//  Module      : seq_watchdog
//  Description : Per-task watchdog counter. Cleared when a task is started,
//                counts enabled cycles, flags expiry at TIMEOUT-1.
//  Ports       : clk, reset (async, active-high)
//                clear   - zero the count (has priority over enable)
//                enable  - count this cycle
//                expired - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_watchdog
    import game_pkg::*;
#(
    parameter int TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                C_CNT_W = $clog2(TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(TIMEOUT - 1);

    logic [C_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != C_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/frame_sequencer.sv
// ============================================================================
//  Module      : frame_sequencer
//  Description : On each vsync rising edge (when enabled) starts the game
//                task slots one after another, waiting for each task's done
//                or its watchdog expiry. Frame starts arriving mid-sequence
//                are dropped and recorded in sticky error status.
//  Ports       : clk, reset (async, active-high)
//                bus (frame_sequencer_if.slave): vsync, enable, err_clr,
//                task_done in; task_start, busy, frame_count, overrun,
//                dropped, task_timeout out
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_sequencer
    import game_pkg::*;
#(
    parameter int NTASK   = C_NTASK_DEF,
    parameter int TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    frame_sequencer_if.slave  bus
);

    localparam int                 C_IDX_W    = $clog2(NTASK);
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(NTASK - 1);

    seq_state_t               r_state;
    seq_state_t               w_state_nxt;
    logic [C_IDX_W-1:0]       r_idx;
    logic [C_IDX_W-1:0]       w_idx_nxt;
    logic                     r_vsync_d;
    logic [C_FRAME_CNT_W-1:0] r_frame_count;
    logic                     r_overrun;
    logic [C_DROP_CNT_W-1:0]  r_dropped;
    logic [NTASK-1:0]         r_task_timeout;

    logic                     w_frame_tick;
    logic                     w_drop;
    logic                     w_seq_start;
    logic                     w_advance;
    logic                     w_wd_clear;
    logic                     w_wd_en;
    logic                     w_wd_expired;
    logic [NTASK-1:0]         w_task_start;
    logic [NTASK-1:0]         w_timeout_set;

    assign w_frame_tick = bus.vsync & ~r_vsync_d;
    // A frame start while a sequence is running is dropped, never queued.
    assign w_drop       = w_frame_tick & (r_state != ST_IDLE);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_wd_clear),
        .enable  (w_wd_en),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_vsync_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_vsync_d <= bus.vsync;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_task_start  = '0;
        w_timeout_set = '0;
        w_wd_clear    = 1'b0;
        w_wd_en       = 1'b0;
        w_seq_start   = 1'b0;
        w_advance     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_frame_tick && bus.enable) begin
                    w_seq_start = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // done is deliberately not looked at here: only the WAIT
                // cycles following the start pulse can complete a task.
                w_task_start[r_idx] = 1'b1;
                w_wd_clear          = 1'b1;
                w_state_nxt         = ST_WAIT;
            end
            ST_WAIT: begin
                // done is checked before expiry so a late done still counts.
                if (bus.task_done[r_idx]) begin
                    w_advance = 1'b1;
                end else if (w_wd_expired) begin
                    w_timeout_set[r_idx] = 1'b1;
                    w_advance            = 1'b1;
                end else begin
                    w_wd_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_advance) begin
            if (r_idx == C_LAST_IDX) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_idx_nxt   = r_idx + 1'b1;
                w_state_nxt = ST_ISSUE;
            end
        end
    end

    // Status registers: a set event in the same cycle as err_clr survives
    // the clear (dropped restarts at 1, new timeout bits are kept).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count  <= '0;
            r_overrun      <= 1'b0;
            r_dropped      <= '0;
            r_task_timeout <= '0;
        end else begin
            if (w_seq_start) begin
                r_frame_count <= r_frame_count + 1'b1;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
                r_dropped <= bus.err_clr ? C_DROP_CNT_W'(1) : sat_inc_drop(r_dropped);
            end else if (bus.err_clr) begin
                r_overrun <= 1'b0;
                r_dropped <= '0;
            end

            r_task_timeout <= (bus.err_clr ? '0 : r_task_timeout) | w_timeout_set;
        end
    end

    assign bus.task_start   = w_task_start;
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.frame_count  = r_frame_count;
    assign bus.overrun      = r_overrun;
    assign bus.dropped      = r_dropped;
    assign bus.task_timeout = r_task_timeout;

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ============================================================================
//  Module      : tb_frame_sequencer
//  Description : Self-checking bench for frame_sequencer (NTASK=4,
//                TIMEOUT=16): vector table for the basic sequence, directed
//                corner sequences, randomized traffic against a
//                frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_sequencer;
    import game_pkg::*;

    localparam int C_NTASK   = 4;
    localparam int C_TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;

    frame_sequencer_if #(.NTASK(C_NTASK)) bus();

    frame_sequencer #(
        .NTASK   (C_NTASK),
        .TIMEOUT (C_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vsync     = 1'b0;
        bus.enable    = 1'b1;
        bus.err_clr   = 1'b0;
        bus.task_done = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- reference model (task cursor + counters) -------------
    int         m_cur;      // running task slot, -1 when no frame in progress
    bit         m_fresh;    // start pulse for m_cur is due this cycle
    int         m_waited;   // wait cycles spent on m_cur so far
    bit         m_vprev;
    int         m_frames;
    bit         m_ov;
    int         m_drops;
    logic [3:0] m_tmo;

    task automatic model_reset();
        m_cur = -1; m_fresh = 0; m_waited = 0; m_vprev = 0;
        m_frames = 0; m_ov = 0; m_drops = 0; m_tmo = '0;
    endtask

    task automatic model_step(input bit vs, input bit en, input logic [3:0] dn, input bit clr);
        bit         tick_ev;
        bit         running;
        bit         finished;
        logic [3:0] tset;
        tick_ev  = vs && !m_vprev;
        m_vprev  = vs;
        running  = (m_cur >= 0);
        finished = 0;
        tset     = '0;
        if (!running) begin
            if (tick_ev && en) begin
                m_frames = (m_frames + 1) % 65536;
                m_cur    = 0;
                m_fresh  = 1;
            end
        end else if (m_fresh) begin
            m_fresh  = 0;
            m_waited = 0;
        end else begin
            m_waited++;
            if (dn[m_cur]) finished = 1;
            else if (m_waited == C_TIMEOUT) begin
                tset[m_cur] = 1'b1;
                finished    = 1;
            end
        end
        if (finished) begin
            m_cur   = (m_cur == C_NTASK - 1) ? -1 : m_cur + 1;
            m_fresh = (m_cur >= 0);
        end
        if (tick_ev && running) begin
            m_ov    = 1;
            m_drops = clr ? 1 : ((m_drops >= 255) ? 255 : m_drops + 1);
        end else if (clr) begin
            m_ov    = 0;
            m_drops = 0;
        end
        m_tmo = (clr ? 4'b0 : m_tmo) | tset;
    endtask

    task automatic random_phase(input int ncyc, input int vs_mod, input int dn_mod, input int clr_mod);
        logic [3:0] exp_start;
        logic [3:0] dn;
        for (int c = 0; c < ncyc; c++) begin
            dn = '0;
            for (int b = 0; b < C_NTASK; b++) dn[b] = (($urandom % dn_mod) == 0);
            bus.vsync     = (($urandom % vs_mod) == 0);
            bus.enable    = (($urandom % 8) != 0);
            bus.err_clr   = (clr_mod > 0) && (($urandom % clr_mod) == 0);
            bus.task_done = dn;
            #1;
            exp_start = (m_cur >= 0 && m_fresh) ? (4'b0001 << m_cur) : 4'b0000;
            check("rnd task_start",   bus.task_start,   exp_start);
            check("rnd busy",         bus.busy,         (m_cur >= 0));
            check("rnd frame_count",  bus.frame_count,  m_frames);
            check("rnd overrun",      bus.overrun,      m_ov);
            check("rnd dropped",      bus.dropped,      m_drops);
            check("rnd task_timeout", bus.task_timeout, m_tmo);
            model_step(bus.vsync, bus.enable, dn, bus.err_clr);
            tick();
        end
    endtask

    // Runs one frame: vsync pulse at iteration 0, then answers each start
    // with done dly[i] cycles later (0 = never). Optional second vsync pulse
    // and err_clr pulse at given iterations.
    task automatic run_seq(input int dly[4], input int vs2_at, input int err_at,
                           output int busy_cyc, output int n_starts, output bit order_ok);
        int pend;
        int age;
        bit done_ok;
        pend = -1; age = 0; done_ok = 0;
        busy_cyc = 0; n_starts = 0; order_ok = 1;
        for (int it = 0; it < 400; it++) begin
            bus.vsync     = (it == 0) || (it == vs2_at);
            bus.err_clr   = (it == err_at);
            bus.task_done = '0;
            if (pend >= 0) begin
                age++;
                if (dly[pend] != 0 && age == dly[pend]) begin
                    bus.task_done[pend] = 1'b1;
                    pend = -1;
                end
            end
            #1;
            if (bus.task_start != '0) begin
                if (n_starts >= C_NTASK || bus.task_start !== (4'b0001 << n_starts)) order_ok = 0;
                pend = $clog2(bus.task_start);
                age  = 0;
                n_starts++;
            end
            if (bus.busy) busy_cyc++;
            else if (it > 1) begin
                done_ok = 1;
                break;
            end
            tick();
        end
        if (!done_ok) check("run_seq cycle budget", 1, 0);
        idle_inputs();
    endtask

    typedef struct {
        logic       vsync;
        logic [3:0] done;
        logic [3:0] exp_start;
        logic       exp_busy;
    } vec_t;

    vec_t vt[21];

    initial begin : watchdog_timer
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int  dly[4];
        int  bc;
        int  ns;
        bit  ok;

        // Basic sequence: vsync rises at cycle 10, each done one cycle
        // after its start.
        for (int c = 0; c < 21; c++) begin
            vt[c].vsync     = (c >= 10 && c <= 12);
            vt[c].done      = (c == 12) ? 4'b0001 : (c == 14) ? 4'b0010 :
                              (c == 16) ? 4'b0100 : (c == 18) ? 4'b1000 : 4'b0000;
            vt[c].exp_start = (c == 11) ? 4'b0001 : (c == 13) ? 4'b0010 :
                              (c == 15) ? 4'b0100 : (c == 17) ? 4'b1000 : 4'b0000;
            vt[c].exp_busy  = (c >= 11 && c <= 18);
        end

        idle_inputs();
        reset = 1'b1;
        #1;
        do_reset();

        check("reset task_start",   bus.task_start,   0);
        check("reset busy",         bus.busy,         0);
        check("reset frame_count",  bus.frame_count,  0);
        check("reset overrun",      bus.overrun,      0);
        check("reset dropped",      bus.dropped,      0);
        check("reset task_timeout", bus.task_timeout, 0);

        for (int c = 0; c < 21; c++) begin
            bus.vsync     = vt[c].vsync;
            bus.task_done = vt[c].done;
            #1;
            check($sformatf("vec%0d task_start", c), bus.task_start, vt[c].exp_start);
            check($sformatf("vec%0d busy", c),       bus.busy,       vt[c].exp_busy);
            tick();
        end
        idle_inputs();
        check("basic frame_count", bus.frame_count, 1);
        check("basic overrun",     bus.overrun,     0);

        // Task 2 never completes: watchdog expiry after 16 wait cycles.
        do_reset();
        dly = '{1, 1, 0, 1};
        run_seq(dly, -1, -1, bc, ns, ok);
        check("tmo task_timeout", bus.task_timeout, 4'b0100);
        check("tmo busy cycles",  bc, 23);
        check("tmo starts",       ns, 4);
        check("tmo order",        ok, 1);
        check("tmo busy end",     bus.busy, 0);

        // Second vsync while task 1 is outstanding.
        do_reset();
        dly = '{1, 8, 1, 1};
        run_seq(dly, 6, -1, bc, ns, ok);
        check("ovr overrun",     bus.overrun,     1);
        check("ovr dropped",     bus.dropped,     1);
        check("ovr frame_count", bus.frame_count, 1);
        check("ovr busy cycles", bc, 15);
        check("ovr order",       ok, 1);

        // Drop and err_clr in the same cycle, then err_clr alone.
        dly = '{1, 8, 1, 0};
        run_seq(dly, 6, 6, bc, ns, ok);
        check("clr+drop dropped",      bus.dropped,      1);
        check("clr+drop overrun",      bus.overrun,      1);
        check("clr+drop task_timeout", bus.task_timeout, 4'b1000);
        check("clr+drop frame_count",  bus.frame_count,  2);
        check("clr+drop busy cycles",  bc, 30);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        #1;
        check("clr overrun",      bus.overrun,      0);
        check("clr dropped",      bus.dropped,      0);
        check("clr task_timeout", bus.task_timeout, 0);
        check("clr frame_count",  bus.frame_count,  2);

        // Asynchronous reset while waiting on task 1.
        do_reset();
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        check("rst start0", bus.task_start, 4'b0001);
        tick();
        bus.task_done = 4'b0001;
        tick();
        bus.task_done = 4'b0000;
        check("rst start1", bus.task_start, 4'b0010);
        tick();
        check("rst busy before", bus.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async task_start",  bus.task_start,  0);
        check("async busy",        bus.busy,        0);
        check("async frame_count", bus.frame_count, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("post-rst no start", bus.task_start, 0);
            tick();
        end
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        check("post-rst start0",      bus.task_start,  4'b0001);
        check("post-rst frame_count", bus.frame_count, 1);

        // enable low at the vsync rise; stray done bits ignored.
        do_reset();
        bus.enable = 1'b0;
        bus.vsync  = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            check("dis no start", bus.task_start, 0);
            tick();
        end
        bus.enable = 1'b1;
        tick();
        check("en held-high no start", bus.task_start, 0);
        check("dis frame_count",       bus.frame_count, 0);
        bus.vsync = 1'b0;
        tick();
        bus.vsync = 1'b1;
        tick();
        bus.vsync     = 1'b0;
        bus.task_done = 4'b0001;    // during ISSUE: ignored
        check("ign start0", bus.task_start, 4'b0001);
        tick();
        bus.task_done = 4'b1000;    // other slot during WAIT: ignored
        tick();
        check("ign still waiting", bus.busy, 1);
        check("ign no start",      bus.task_start, 0);
        bus.task_done = 4'b0001;
        tick();
        bus.task_done = 4'b0000;
        check("ign start1", bus.task_start, 4'b0010);

        // Randomized traffic, then heavy vsync traffic to saturate dropped.
        do_reset();
        random_phase(2000, 6, 3, 40);
        random_phase(2000, 2, 64, 0);
        #1;
        check("dropped saturated", bus.dropped, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
